// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves host upload byte reads from 16-bit Hack RAM through a one-word cache
module ioctl_upload_reader #(
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [15:0]       mem_q,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              req_q, req_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              sel_q, sel_d;
  logic [MEM_AW-1:0] cache_addr_q, cache_addr_d;
  logic [15:0]       cache_data_q, cache_data_d;
  logic              cache_valid_q, cache_valid_d;
  logic [MEM_AW-1:0] word;
  logic              hit;
  logic              unused_addr;
  // upper host address bits are deliberately dropped so addresses wrap
  assign unused_addr = ^ioctl_addr;
  assign word = ioctl_addr[MEM_AW:1];
  assign hit  = cache_valid_q && (word == cache_addr_q);
  // next-state: upload low aborts everything; otherwise IDLE -> (hit | REQ) -> DATA -> IDLE
  always_comb begin
    state_d       = state_q;
    din_d         = din_q;
    wait_d        = wait_q;
    req_d         = req_q;
    addr_d        = addr_q;
    sel_d         = sel_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;
    cache_valid_d = cache_valid_q;
    if (!ioctl_upload) begin
      state_d       = IDLE;
      req_d         = 1'b0;
      wait_d        = 1'b0;
      cache_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ioctl_rd) begin
          if (hit) begin
            din_d = ioctl_addr[0] ? cache_data_q[15:8] : cache_data_q[7:0];
          end else begin
            addr_d  = word;
            sel_d   = ioctl_addr[0];
            req_d   = 1'b1;
            wait_d  = 1'b1;
            state_d = REQ;
          end
        end
        REQ: if (mem_gnt) begin
          req_d   = 1'b0;
          state_d = DATA;
        end
        DATA: begin
          cache_data_d  = mem_q;
          cache_addr_d  = addr_q;
          cache_valid_d = 1'b1;
          din_d         = sel_q ? mem_q[15:8] : mem_q[7:0];
          wait_d        = 1'b0;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers, cleared immediately by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      din_q         <= 8'h00;
      wait_q        <= 1'b0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      sel_q         <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= 16'h0000;
      cache_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_q         <= din_d;
      wait_q        <= wait_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      sel_q         <= sel_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
      cache_valid_q <= cache_valid_d;
    end
  end
  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign busy       = (state_q != IDLE);
endmodule
